lcd_de_rx: RTL and testbench



---
 rtl/lcd_pkg.sv | 19 +
 rtl/lcd_rx_gap_detector.sv | 39 +++
 rtl/lcd_de_rx.sv | 189 ++++++++++++++++++
 tb/tb_lcd_de_rx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, receiver state encoding and pixel helper for the LCD DE-mode path.
package lcd_pkg;

  localparam int LCD_WIDTH  = 640;
  localparam int LCD_HEIGHT = 480;
  localparam int H_BLANKING = 160;
  localparam int V_BLANKING = 45;
  localparam int LCD_CW     = 10;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VBLANK = 2'd1;
  localparam logic [1:0] ST_LINE   = 2'd2;
  localparam logic [1:0] ST_HBLANK = 2'd3;

  function automatic logic [15:0] rgb_sum(input logic [23:0] p);
    return {8'h00, p[23:16]} + {8'h00, p[15:8]} + {8'h00, p[7:0]};
  endfunction

endpackage

// File: rtl/lcd_rx_gap_detector.sv
// Saturating count of consecutive DE-low samples; gap_hit marks the sample that
// brings the count to THRESH, so it fires exactly once per blanking gap.
module lcd_rx_gap_detector #(
  parameter int THRESH = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic de,
  output logic gap_hit
);

  localparam int GW = $clog2(THRESH + 1);
  localparam logic [GW-1:0] SAT_VAL = GW'(THRESH);
  localparam logic [GW-1:0] HIT_VAL = GW'(THRESH - 1);

  logic [GW-1:0] cnt;

  // Low-run counter, cleared by any active sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (de) begin
      cnt <= '0;
    end else if (cnt != SAT_VAL) begin
      cnt <= cnt + GW'(1);
    end
  end

  // Hit on the low sample that completes the threshold.
  always_comb begin
    gap_hit = 1'b0;
    if (!de && (cnt == HIT_VAL)) begin
      gap_hit = 1'b1;
    end else begin
      gap_hit = 1'b0;
    end
  end

endmodule

// File: rtl/lcd_de_rx.sv
// DE-only RGB receiver: recovers frame/line timing, coordinates and geometry errors.
// Optional frame checksum enabled by defining LCD_RX_CHECKSUM_EN.
module lcd_de_rx
  import lcd_pkg::*;
#(
  parameter int EXP_WIDTH     = LCD_WIDTH,
  parameter int EXP_HEIGHT    = LCD_HEIGHT,
  parameter int VBLANK_THRESH = 1000,
  parameter int CW            = LCD_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          de,
  input  logic [23:0]   rgb_in,
  output logic          pix_valid,
  output logic [23:0]   pix_rgb,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          sof,
  output logic          line_done,
  output logic          frame_done,
  output logic [CW-1:0] meas_width,
  output logic [CW-1:0] meas_height,
  output logic          err_line,
  output logic          err_frame,
  output logic          locked,
  output logic [15:0]   frame_sum
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] EXP_W   = CW'(EXP_WIDTH);
  localparam logic [CW-1:0] EXP_H   = CW'(EXP_HEIGHT);

  logic [1:0]    state;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          frame_bad;
  logic          gap_hit;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CW'(1);
    end
  endfunction

  lcd_rx_gap_detector #(
    .THRESH (VBLANK_THRESH)
  ) u_gap (
    .clk     (clk),
    .rst_n   (rst_n),
    .de      (de),
    .gap_hit (gap_hit)
  );

  // Receiver FSM with registered pixel, strobe and measurement outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_SEARCH;
      x           <= '0;
      y           <= '0;
      frame_bad   <= 1'b0;
      pix_valid   <= 1'b0;
      pix_rgb     <= 24'h000000;
      pix_x       <= '0;
      pix_y       <= '0;
      sof         <= 1'b0;
      line_done   <= 1'b0;
      frame_done  <= 1'b0;
      meas_width  <= '0;
      meas_height <= '0;
      err_line    <= 1'b0;
      err_frame   <= 1'b0;
      locked      <= 1'b0;
    end else begin
      pix_valid  <= 1'b0;
      pix_rgb    <= 24'h000000;
      sof        <= 1'b0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      err_line   <= 1'b0;
      err_frame  <= 1'b0;
      case (state)
        ST_SEARCH: begin
          if (gap_hit) begin
            state <= ST_VBLANK;
          end
        end
        ST_VBLANK: begin
          if (de) begin
            state     <= ST_LINE;
            pix_valid <= 1'b1;
            pix_rgb   <= rgb_in;
            pix_x     <= '0;
            pix_y     <= '0;
            sof       <= 1'b1;
            x         <= CW'(1);
            y         <= '0;
            frame_bad <= 1'b0;
          end
        end
        ST_LINE: begin
          if (de) begin
            pix_valid <= 1'b1;
            pix_rgb   <= rgb_in;
            pix_x     <= x;
            pix_y     <= y;
            x         <= sat_inc(x);
          end else begin
            state      <= ST_HBLANK;
            line_done  <= 1'b1;
            meas_width <= x;
            x          <= '0;
            y          <= sat_inc(y);
            if (x != EXP_W) begin
              err_line  <= 1'b1;
              locked    <= 1'b0;
              frame_bad <= 1'b1;
            end
          end
        end
        ST_HBLANK: begin
          if (de) begin
            state     <= ST_LINE;
            pix_valid <= 1'b1;
            pix_rgb   <= rgb_in;
            pix_x     <= '0;
            pix_y     <= y;
            x         <= CW'(1);
          end else if (gap_hit) begin
            state       <= ST_VBLANK;
            frame_done  <= 1'b1;
            meas_height <= y;
            if (y != EXP_H) begin
              err_frame <= 1'b1;
              locked    <= 1'b0;
            end else begin
              locked <= ~frame_bad;
            end
          end
        end
        default: begin
          state <= ST_SEARCH;
        end
      endcase
    end
  end

`ifdef LCD_RX_CHECKSUM_EN
  logic        take_first;
  logic        take_pix;
  logic        take_end;
  logic [15:0] acc;

  // Decode the FSM transitions that drive the accumulator.
  always_comb begin
    take_first = 1'b0;
    take_pix   = 1'b0;
    take_end   = 1'b0;
    if (de) begin
      take_first = (state == ST_VBLANK);
      take_pix   = (state == ST_LINE) || (state == ST_HBLANK);
    end else begin
      take_end = (state == ST_HBLANK) && gap_hit;
    end
  end

  // Per-frame channel-sum accumulator, restarted by the first pixel of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= 16'h0000;
      frame_sum <= 16'h0000;
    end else begin
      if (take_first) begin
        acc <= rgb_sum(rgb_in);
      end else if (take_pix) begin
        acc <= acc + rgb_sum(rgb_in);
      end
      if (take_end) begin
        frame_sum <= acc;
      end
    end
  end
`else
  assign frame_sum = 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_de_rx.sv
// Directed bench for lcd_de_rx using a reduced panel geometry (64x8, 16-cycle hblank).
module tb_lcd_de_rx;

  localparam int TW  = 64;
  localparam int TH  = 8;
  localparam int TT  = 100;
  localparam int HB  = 16;
  localparam int LP  = TW + HB;
  localparam int VBL = 3;
  localparam logic [23:0] PIX = 24'h010203;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        de = 1'b0;
  logic [23:0] rgb_in = 24'h000000;
  logic        pix_valid;
  logic [23:0] pix_rgb;
  logic [9:0]  pix_x, pix_y, meas_width, meas_height;
  logic        sof, line_done, frame_done, err_line, err_frame, locked;
  logic [15:0] frame_sum;
  logic [86:0] outs;

  int checks = 0;
  int errors = 0;
  int n_sof = 0, n_ld = 0, n_fd = 0, n_el = 0, n_ef = 0;
  logic [9:0]  el_width = 10'd0, fd_height = 10'd0, sof_x = 10'd0, sof_y = 10'd0, last_x = 10'd0;
  logic        el_locked = 1'b0;
  logic [23:0] sof_rgb = 24'h000000;
  int b_sof, b_ld, b_fd, b_el, b_ef;

  lcd_de_rx #(
    .EXP_WIDTH (TW), .EXP_HEIGHT (TH), .VBLANK_THRESH (TT), .CW (10)
  ) dut (
    .clk (clk), .rst_n (rst_n), .de (de), .rgb_in (rgb_in),
    .pix_valid (pix_valid), .pix_rgb (pix_rgb), .pix_x (pix_x), .pix_y (pix_y),
    .sof (sof), .line_done (line_done), .frame_done (frame_done),
    .meas_width (meas_width), .meas_height (meas_height),
    .err_line (err_line), .err_frame (err_frame), .locked (locked),
    .frame_sum (frame_sum)
  );

  assign outs = {pix_valid, pix_rgb, pix_x, pix_y, sof, line_done, frame_done,
                 meas_width, meas_height, err_line, err_frame, locked, frame_sum};

  always #5 clk = ~clk;

  // Event recorder sampled on the falling edge, away from output updates.
  always @(negedge clk) begin
    if (sof) begin
      n_sof   <= n_sof + 1;
      sof_x   <= pix_x;
      sof_y   <= pix_y;
      sof_rgb <= pix_rgb;
    end
    if (pix_valid) last_x <= pix_x;
    if (line_done) n_ld <= n_ld + 1;
    if (frame_done) begin
      n_fd      <= n_fd + 1;
      fd_height <= meas_height;
    end
    if (err_line) begin
      n_el      <= n_el + 1;
      el_width  <= meas_width;
      el_locked <= locked;
    end
    if (err_frame) n_ef <= n_ef + 1;
  end

  task automatic snap();
    b_sof = n_sof; b_ld = n_ld; b_fd = n_fd; b_el = n_el; b_ef = n_ef;
  endtask

  task automatic drive_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      de = 1'b1; rgb_in = PIX;
    end
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      de = 1'b0; rgb_in = 24'h000000;
    end
  endtask

  task automatic drive_frame(input int h, input int short_idx, input int short_w);
    for (int l = 0; l < h; l++) begin
      drive_pixels((l == short_idx) ? short_w : TW);
      drive_idle(HB);
    end
    drive_idle(VBL * LP);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; de = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== 87'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    logic [15:0] exp_sum;
`ifdef LCD_RX_CHECKSUM_EN
    exp_sum = 16'h0C00;
`else
    exp_sum = 16'h0000;
`endif
    snap();
    drive_frame(TH, -1, 0);
    checks++;
    if (n_sof - b_sof !== 0) begin
      errors++; $display("FAIL search_no_sof got %0d want 0", n_sof - b_sof);
    end
    checks++;
    if (n_fd - b_fd !== 0 || n_ld - b_ld !== 0) begin
      errors++; $display("FAIL search_no_strobes got fd=%0d ld=%0d want 0", n_fd - b_fd, n_ld - b_ld);
    end
    snap();
    drive_frame(TH, -1, 0);
    checks++;
    if (n_sof - b_sof !== 1 || sof_x !== 10'd0 || sof_y !== 10'd0) begin
      errors++; $display("FAIL nominal_sof got n=%0d x=%0d y=%0d want 1,0,0", n_sof - b_sof, sof_x, sof_y);
    end
    checks++;
    if (sof_rgb !== PIX) begin
      errors++; $display("FAIL nominal_rgb got %h want %h", sof_rgb, PIX);
    end
    checks++;
    if (n_ld - b_ld !== TH) begin
      errors++; $display("FAIL nominal_lines got %0d want %0d", n_ld - b_ld, TH);
    end
    checks++;
    if (meas_width !== 10'd64 || meas_height !== 10'd8) begin
      errors++; $display("FAIL nominal_geom got %0dx%0d want 64x8", meas_width, meas_height);
    end
    checks++;
    if (locked !== 1'b1 || n_el - b_el !== 0 || n_ef - b_ef !== 0) begin
      errors++; $display("FAIL nominal_lock got locked=%b el=%0d ef=%0d want 1,0,0", locked, n_el - b_el, n_ef - b_ef);
    end
    checks++;
    if (frame_sum !== exp_sum) begin
      errors++; $display("FAIL nominal_sum got %h want %h", frame_sum, exp_sum);
    end
  endtask

  task automatic test_short_line();
    snap();
    drive_frame(TH, 3, TW - 1);
    checks++;
    if (n_el - b_el !== 1 || el_width !== 10'd63) begin
      errors++; $display("FAIL short_err got n=%0d w=%0d want 1,63", n_el - b_el, el_width);
    end
    checks++;
    if (el_locked !== 1'b0 || locked !== 1'b0) begin
      errors++; $display("FAIL short_lock got at_err=%b after=%b want 0,0", el_locked, locked);
    end
    checks++;
    if (n_ef - b_ef !== 0 || fd_height !== 10'd8) begin
      errors++; $display("FAIL short_height got ef=%0d h=%0d want 0,8", n_ef - b_ef, fd_height);
    end
    drive_frame(TH, -1, 0);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL short_relock got %b want 1", locked);
    end
  endtask

  task automatic test_height();
    snap();
    drive_frame(TH - 1, -1, 0);
    checks++;
    if (n_ef - b_ef !== 1 || meas_height !== 10'd7) begin
      errors++; $display("FAIL height_err got n=%0d h=%0d want 1,7", n_ef - b_ef, meas_height);
    end
    checks++;
    if (locked !== 1'b0 || n_el - b_el !== 0) begin
      errors++; $display("FAIL height_lock got locked=%b el=%0d want 0,0", locked, n_el - b_el);
    end
    drive_frame(TH, -1, 0);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL height_relock got %b want 1", locked);
    end
  endtask

  task automatic test_midframe_reset();
    for (int l = 0; l < 4; l++) begin
      drive_pixels(TW);
      drive_idle(HB);
    end
    drive_pixels(10);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      de = 1'b1; rgb_in = PIX;
      checks++;
      if (outs !== 87'd0) begin
        errors++; $display("FAIL midreset_outputs cycle %0d got %h want 0", i, outs);
      end
    end
    rst_n = 1'b1;
    snap();
    drive_pixels(TW - 13);
    drive_idle(HB);
    drive_frame(TH - 5, -1, 0);
    checks++;
    if (n_sof - b_sof !== 0 || n_fd - b_fd !== 0) begin
      errors++; $display("FAIL midreset_discard got sof=%0d fd=%0d want 0,0", n_sof - b_sof, n_fd - b_fd);
    end
    snap();
    drive_frame(TH, -1, 0);
    checks++;
    if (n_sof - b_sof !== 1 || meas_width !== 10'd64 || meas_height !== 10'd8 || locked !== 1'b1) begin
      errors++; $display("FAIL midreset_resync got sof=%0d %0dx%0d locked=%b want 1 64x8 1",
                         n_sof - b_sof, meas_width, meas_height, locked);
    end
  endtask

  task automatic test_saturate();
    snap();
    drive_pixels(1100);
    drive_idle(HB);
    checks++;
    if (last_x !== 10'd1023) begin
      errors++; $display("FAIL sat_pix_x got %0d want 1023", last_x);
    end
    checks++;
    if (n_el - b_el !== 1 || el_width !== 10'd1023) begin
      errors++; $display("FAIL sat_err got n=%0d w=%0d want 1,1023", n_el - b_el, el_width);
    end
    drive_idle(VBL * LP);
  endtask

  task automatic test_glitch();
    snap();
    drive_pixels(1);
    drive_idle(VBL * LP);
    checks++;
    if (n_el - b_el !== 1 || el_width !== 10'd1) begin
      errors++; $display("FAIL glitch_err got n=%0d w=%0d want 1,1", n_el - b_el, el_width);
    end
    checks++;
    if (n_ef - b_ef !== 1 || fd_height !== 10'd1 || locked !== 1'b0) begin
      errors++; $display("FAIL glitch_frame got ef=%0d h=%0d locked=%b want 1,1,0", n_ef - b_ef, fd_height, locked);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short_line();
    test_height();
    test_midframe_reset();
    test_saturate();
    test_glitch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
